instr_fetch: RTL and testbench

Instruction fetch sequencer that sits directly upstream of the instruction decoder. On a start command it walks a contiguous range of the instruction memory, buffers the returned 28-bit instruction words in a small FIFO, and presents them to the decoder one per cycle through a d/en handshake gated by downstream readiness. It reports busy/done to the top-level controller.

---
 rtl/instr_fetch_if.sv | 29 ++
 rtl/instr_fetch.sv | 110 +++++++++++
 tb/tb_instr_fetch.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Bundle between the fetch sequencer, the controller, the instruction memory and the decoder.
// The master modport is the fetch unit's view; slave is the surrounding system's view.
interface instr_fetch_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   instr_count;
  logic              busy;
  logic              done;
  logic              imem_rd_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [27:0]       imem_rdata;
  logic              dec_ready;
  logic [27:0]       d;
  logic              en;

  // Decoder handshake: en = FIFO non-empty & dec_ready; the decoder latches d and the
  // FIFO head is popped on every rising edge where en=1. d is meaningless while en=0.
  modport master (
    input  start, base_addr, instr_count, imem_rdata, dec_ready,
    output busy, done, imem_rd_en, imem_addr, d, en
  );

  modport slave (
    output start, base_addr, instr_count, imem_rdata, dec_ready,
    input  busy, done, imem_rd_en, imem_addr, d, en
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: walks a contiguous instruction range, buffers returned
// words in a small FIFO and feeds the decoder one word per cycle under dec_ready.
module instr_fetch #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus,
  output logic [1:0]    dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   remaining;
  logic              inflight;
  logic [27:0]       mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [27:0]       last_d;
  logic [CW:0]       credit_used;
  logic              accept, issue, push, pop;

  // Credit counts the slot reserved by an outstanding read; a same-cycle pop frees nothing.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign accept      = (state == IDLE) && bus.start;
  assign issue       = (state == FETCH) && (remaining != '0) && (credit_used < DEPTH_C);
  assign push        = inflight;
  assign pop         = (count != '0) && bus.dec_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (bus.instr_count == '0) ? DONE : FETCH;
      end
      FETCH: begin
        if (issue && (remaining == (ADDR_W+1)'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Leave as soon as the final pop empties the FIFO so done follows the last en directly.
        if (!inflight && ((count == '0) || ((count == CW'(1)) && pop))) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state != IDLE);
    bus.done       = (state == DONE);
    bus.imem_rd_en = issue;
    bus.imem_addr  = pc;
    bus.en         = pop;
    bus.d          = (count != '0) ? mem[rd_ptr] : last_d;
    dbg_state      = state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_d    <= '0;
    end else begin
      inflight <= issue;
      if (accept) begin
        pc        <= bus.base_addr;
        remaining <= bus.instr_count;
      end else if (issue) begin
        pc        <= pc + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_d <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.imem_rdata;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a transaction-level model
// (expected address/word queues plus FIFO occupancy and read-credit bookkeeping).
module tb_instr_fetch;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  logic [7:0] salt;
  int         n_checks = 0;
  int         n_err    = 0;

  instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [27:0] word_of(input logic [9:0] a);
    return {salt, a, ~a};
  endfunction

  // Instruction memory: data valid exactly one cycle after the read strobe
  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_rdata <= word_of(bus.imem_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_rd_en"}, 32'(bus.imem_rd_en), 32'(0));
    check_eq({tag, "_addr"},  32'(bus.imem_addr),  32'(0));
    check_eq({tag, "_en"},    32'(bus.en),         32'(0));
    check_eq({tag, "_d"},     32'(bus.d),          32'(0));
    check_eq({tag, "_busy"},  32'(bus.busy),       32'(0));
    check_eq({tag, "_done"},  32'(bus.done),       32'(0));
    check_eq({tag, "_state"}, 32'(dbg_state),      32'(0));
  endtask

  function automatic bit ready_for(input int mode, input int stall, input int c);
    if (mode == 1) return $urandom_range(0, 1) == 1;
    if (mode == 2) return c >= stall;
    return 1'b1;
  endfunction

  // mode: 0 ready always high, 1 random ready, 2 ready low for 'stall' cycles.
  // restart_cyc >= 0 pulses a conflicting start in that cycle, which must be ignored.
  task automatic run_case(input logic [9:0] base, input logic [10:0] n, input int mode,
                          input int stall, input int restart_cyc);
    logic [27:0] exp_q[$];
    logic [9:0]  addr_q[$];
    logic [9:0]  a;
    int occ, rem, c, reads, ens, first_rd, first_en, done_cyc, early_rd;
    bit infl, finished, stop, exp_rd, exp_en, exp_done, exp_busy;
    salt = 8'($urandom);
    for (int i = 0; i < int'(n); i++) begin
      a = base + 10'(i);
      addr_q.push_back(a);
      exp_q.push_back(word_of(a));
    end
    occ = 0; rem = 0; c = 0; reads = 0; ens = 0;
    first_rd = -1; first_en = -1; done_cyc = -1; early_rd = 0;
    infl = 1'b0; finished = 1'b0;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.base_addr   = base;
    bus.instr_count = n;
    bus.dec_ready   = ready_for(mode, stall, 0);
    while (c < 3000) begin
      #2;
      exp_rd   = (c >= 1) && !finished && (rem > 0) && (occ + int'(infl) < DEPTH);
      exp_en   = (occ > 0) && bus.dec_ready;
      exp_done = (c >= 1) && !finished && (rem == 0) && (occ == 0) && !infl;
      exp_busy = (c >= 1) && !finished;
      check_eq("rd_en", 32'(bus.imem_rd_en), 32'(exp_rd));
      if (bus.imem_rd_en) begin
        reads++;
        if (first_rd < 0) first_rd = c;
        if (c < stall) early_rd++;
        if (addr_q.size() > 0) check_eq("imem_addr", 32'(bus.imem_addr), 32'(addr_q.pop_front()));
        else check_eq("read_count", 32'(reads), 32'(n));
      end
      check_eq("en", 32'(bus.en), 32'(exp_en));
      if (bus.en) begin
        ens++;
        if (first_en < 0) first_en = c;
        if (exp_q.size() > 0) check_eq("d", 32'(bus.d), 32'(exp_q.pop_front()));
        else check_eq("en_count", 32'(ens), 32'(n));
      end
      check_eq("done", 32'(bus.done), 32'(exp_done));
      check_eq("busy", 32'(bus.busy), 32'(exp_busy));
      if (bus.done && done_cyc < 0) done_cyc = c;
      if (c == 0) rem = int'(n);
      occ  = occ + int'(infl) - int'(bus.en);
      infl = bus.imem_rd_en;
      if (bus.imem_rd_en) rem--;
      if (occ > DEPTH) check_eq("fifo_overflow", 32'(occ), 32'(DEPTH));
      stop = finished;
      if (exp_done) finished = 1'b1;
      if (stop) break;
      @(negedge clk);
      c++;
      bus.dec_ready = ready_for(mode, stall, c);
      bus.start     = (c == restart_cyc);
      if (c == restart_cyc) begin
        bus.base_addr   = ~base;
        bus.instr_count = n + 11'd3;
      end
    end
    bus.start = 1'b0;
    check_eq("finished", 32'(finished), 32'(1));
    check_eq("reads_left", 32'(addr_q.size()), 32'(0));
    check_eq("words_left", 32'(exp_q.size()), 32'(0));
    if (mode == 0 && n != 0) begin
      check_eq("first_rd_cyc", 32'(first_rd), 32'(1));
      check_eq("first_en_cyc", 32'(first_en), 32'(3));
      check_eq("done_cyc", 32'(done_cyc), 32'(int'(n) + 3));
    end
    if (n == 0) begin
      check_eq("zero_done_cyc", 32'(done_cyc), 32'(1));
      check_eq("zero_reads", 32'(reads), 32'(0));
      check_eq("zero_ens", 32'(ens), 32'(0));
    end
    if (mode == 2 && int'(n) >= DEPTH && stall > DEPTH + 2)
      check_eq("reads_before_stall", 32'(early_rd), 32'(DEPTH));
  endtask

  task automatic reset_mid_run();
    salt = 8'($urandom);
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 10'h100; bus.instr_count = 11'd6; bus.dec_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #2 check_eq("mid_rd_c1", 32'(bus.imem_rd_en), 32'(1));
    @(negedge clk);
    #2 check_eq("mid_rd_c2", 32'(bus.imem_rd_en), 32'(1));
    reset = 1'b0;
    #1 check_quiet("mid_rst");
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      check_eq("post_rst_en", 32'(bus.en), 32'(0));
      check_eq("post_rst_rd", 32'(bus.imem_rd_en), 32'(0));
      check_eq("post_rst_busy", 32'(bus.busy), 32'(0));
      check_eq("post_rst_d", 32'(bus.d), 32'(0));
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.instr_count = '0; bus.dec_ready = 1'b0;
    salt = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = (i % 2 == 0); bus.base_addr = 10'h155; bus.instr_count = 11'd3; bus.dec_ready = 1'b1;
      #2 check_quiet("in_reset");
    end
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2 check_quiet("idle");
    end

    run_case(10'h010, 11'd5, 0, 0, -1);
    run_case(10'h000, 11'd8, 2, 10, -1);
    run_case(10'h3FE, 11'd4, 0, 0, -1);
    run_case(10'h123, 11'd0, 0, 0, -1);
    run_case(10'h050, 11'd7, 0, 0, 3);
    reset_mid_run();
    run_case(10'h200, 11'd6, 0, 0, -1);
    for (int k = 0; k < 6; k++)
      run_case(10'($urandom_range(0, 1023)), 11'($urandom_range(1, 40)), 1, 0, -1);
    run_case(10'($urandom_range(0, 1023)), 11'($urandom_range(5, 30)), 2,
             $urandom_range(8, 20), -1);
    run_case(10'h2A0, 11'd1024, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
